// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared op encodings and FSM state type for the USR sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/usr_core.sv
`default_nettype none
// ============================================================================
// Module      : usr_core
// Description : WIDTH-bit universal shift register driven by a 2-bit op code.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] par_i,
    output logic [WIDTH-1:0] q_o
);
    import usr_pkg::*;

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            case (op_i)
                OP_LOAD:  shreg_q <= par_i;
                OP_LEFT:  shreg_q <= {shreg_q[WIDTH-2:0], ser_i};
                OP_RIGHT: shreg_q <= {ser_i, shreg_q[WIDTH-1:1]};
                default:  shreg_q <= shreg_q;
            endcase
        end
    end

    assign q_o = shreg_q;

endmodule
`default_nettype wire

// File: rtl/usr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usr_seq_ctrl
// Description : Sequencer running one TX or RX serial transfer through usr_core.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [1:0]       op
);
    import usr_pkg::*;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic             mode_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] par_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] par_out_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic [1:0]       op_q;

    logic [WIDTH-1:0] w_shreg;
    logic [WIDTH-1:0] w_rx_next;
    logic             w_core_ser;

    // Only RX feeds serial data into the register; TX backfills zeros.
    assign w_core_ser = mode_q & ser_in;
    assign w_rx_next  = dir_q ? {ser_in, w_shreg[WIDTH-1:1]}
                              : {w_shreg[WIDTH-2:0], ser_in};

    usr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .op_i  (op_q),
        .ser_i (w_core_ser),
        .par_i (par_q),
        .q_o   (w_shreg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            par_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            par_out_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            op_q        <= OP_HOLD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        dir_q  <= dir;
                        par_q  <= par_in;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (mode) begin
                            state_q <= ST_SHIFT;
                            op_q    <= dir ? OP_RIGHT : OP_LEFT;
                        end else begin
                            state_q <= ST_LOAD;
                            op_q    <= OP_LOAD;
                        end
                    end else begin
                        op_q <= OP_HOLD;
                    end
                end
                ST_LOAD: begin
                    // First TX bit comes straight from the word being loaded.
                    state_q     <= ST_SHIFT;
                    op_q        <= dir_q ? OP_RIGHT : OP_LEFT;
                    ser_valid_q <= 1'b1;
                    ser_out_q   <= dir_q ? par_q[0] : par_q[WIDTH-1];
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_DONE;
                        cnt_q       <= '0;
                        op_q        <= OP_HOLD;
                        done_q      <= 1'b1;
                        ser_valid_q <= 1'b0;
                        ser_out_q   <= 1'b0;
                        if (mode_q) begin
                            par_out_q <= w_rx_next;
                        end
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        ser_out_q <= ~mode_q & (dir_q ? w_shreg[1] : w_shreg[WIDTH-2]);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    op_q    <= OP_HOLD;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign par_out   = par_out_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign op        = op_q;

endmodule
`default_nettype wire

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 3, shift register data width in bits (legal range 2..16).
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst. All flops SHALL update on the rising edge of clk.
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  request to begin one transfer; sampled only in IDLE
- mode  in  1  0 = TX (parallel-in, serial-out), 1 = RX (serial-in, parallel-out)
- dir  in  1  0 = shift left (MSB first out / LSB in), 1 = shift right (LSB first out / MSB in)
- par_in  in  WIDTH  parallel word for TX
- ser_in  in  1  serial data bit for RX
- busy  out  1  high in LOAD, SHIFT and DONE
- done  out  1  one-cycle pulse marking the end of a transfer
- par_out  out  WIDTH  received word; registered, updated only on RX completion
- ser_out  out  1  serial TX bit
- ser_valid  out  1  ser_out is valid this cycle
- op  out  2  operation currently issued to the datapath: 00 hold, 01 left, 10 right, 11 load

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-005 In IDLE with start=1, the block SHALL latch mode and dir, clear the bit counter, and move to LOAD when mode=0 or to SHIFT when mode=1.
REQ-006 In IDLE with start=0, the block SHALL stay in IDLE and drive op=00.
REQ-007 LOAD SHALL last exactly one cycle, drive op=11, load par_in into the internal register, and then move to SHIFT.
REQ-008 SHIFT SHALL last exactly WIDTH cycles, driving op=01 when dir=0 and op=10 when dir=1, and incrementing the counter every cycle.
REQ-009 When the counter equals WIDTH-1, the block SHALL move from SHIFT to DONE.
REQ-010 DONE SHALL last one cycle, assert done=1, then return to IDLE.
REQ-011 TX latency SHALL be WIDTH+2 cycles from the start-sample edge to done; RX latency SHALL be WIDTH+1 cycles.
REQ-012 In a TX SHIFT cycle, ser_valid SHALL be 1, and ser_out SHALL be reg[WIDTH-1] when dir=0 or reg[0] when dir=1, sampled before that cycle's shift.
REQ-013 Outside TX SHIFT cycles, ser_valid and ser_out SHALL both be 0.
REQ-014 In an RX SHIFT cycle, ser_in SHALL enter reg[0] when dir=0 or reg[WIDTH-1] when dir=1.
REQ-015 On the SHIFT-to-DONE edge in RX, par_out SHALL capture the completed register value.
REQ-016 par_out SHALL hold its value through TX transfers and idle periods.
REQ-017 start SHALL be ignored while busy=1, including during DONE; there are no back-to-back transfers without one IDLE cycle.
REQ-018 Changes to mode, dir or par_in while busy=1 SHALL have no effect on the transfer in progress.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-020 Asserting rst SHALL immediately force state=IDLE, counter=0 and register=0, and outputs busy=0, done=0, par_out=0, ser_out=0, ser_valid=0 and op=00.
REQ-021 Reset asserted during LOAD, SHIFT or DONE SHALL abort the transfer with no done pulse and no par_out update.
REQ-022 After rst deasserts, the next start SHALL begin a normal transfer.

Structure
REQ-023 A shared package usr_pkg SHALL hold the op encodings (OP_HOLD=2'b00, OP_LEFT=2'b01, OP_RIGHT=2'b10, OP_LOAD=2'b11) and the FSM state enum.
REQ-024 The shift datapath SHALL be one sub-module, usr_core: a WIDTH-bit register with op, ser_in and par_in inputs and q output, on the same clk and rst. usr_seq_ctrl SHALL contain the FSM, the counter and the output logic.

Verification (WIDTH=3)
REQ-025 TX left: par_in=3'b110, mode=0, dir=0, start pulse -> one LOAD cycle, then ser_valid high for 3 cycles with ser_out=1,1,0, then done pulse on the next cycle.
REQ-026 TX right: par_in=3'b110, dir=1 -> ser_out=0,1,1; par_out unchanged.
REQ-027 RX left: mode=1, dir=0, ser_in=1,0,1 over the SHIFT cycles -> par_out=3'b101 with done; ser_valid=0 throughout.
REQ-028 RX right: mode=1, dir=1, ser_in=1,0,0 -> par_out=3'b001 with done.
REQ-029 start held high continuously -> transfers start on every second IDLE opportunity (done, IDLE, LOAD...); mid-transfer changes to par_in and dir have no effect.
REQ-030 rst asserted in the 2nd SHIFT cycle -> all outputs 0 immediately, no done; a following TX of 3'b011 completes with ser_out=0,1,1.
